// File: rtl/i2s_audio_rx.sv
// I2S capture receiver: synchronises bclk/lrclk/din into clk, de-serialises
// standard I2S words and emits one left/right pair per frame with a valid strobe.
`timescale 1ns/1ps
module i2s_audio_rx #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_din,
  output logic [DATA_WIDTH-1:0] sound_left,
  output logic [DATA_WIDTH-1:0] sound_right,
  output logic                  sample_valid,
  output logic                  link_active
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;

  state_t                state;
  logic                  bclk_meta, bclk_s, bclk_d;
  logic                  lr_meta, lr_s, lr_prev;
  logic                  din_meta, din_s;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, left_hold, word;
  logic [CW-1:0]         bit_cnt, cnt_nxt;
  logic [IW-1:0]         idle_cnt;
  logic                  have_left;
  logic                  bclk_rise, word_end, timeout;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bclk_meta <= 1'b0;
      bclk_s    <= 1'b0;
      bclk_d    <= 1'b0;
      lr_meta   <= 1'b0;
      lr_s      <= 1'b0;
      din_meta  <= 1'b0;
      din_s     <= 1'b0;
    end else begin
      bclk_meta <= i2s_bclk;
      bclk_s    <= bclk_meta;
      bclk_d    <= bclk_s;
      lr_meta   <= i2s_lrclk;
      lr_s      <= lr_meta;
      din_meta  <= i2s_din;
      din_s     <= din_meta;
    end
  end

  assign bclk_rise = bclk_s & ~bclk_d;
  assign word_end  = bclk_rise && (lr_s != lr_prev);
  // A bclk edge in the same cycle always beats an expiring idle counter.
  assign timeout   = !bclk_rise && (idle_cnt == IW'(TIMEOUT_CYCLES));

  // Bits beyond DATA_WIDTH are dropped; short words are left-justified.
  always_comb begin
    shreg_nxt = shreg;
    cnt_nxt   = bit_cnt;
    if (bit_cnt < CW'(DATA_WIDTH)) begin
      shreg_nxt = {shreg[DATA_WIDTH-2:0], din_s};
      cnt_nxt   = bit_cnt + 1'b1;
    end
    word = shreg_nxt << (CW'(DATA_WIDTH) - cnt_nxt);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_SYNC;
      lr_prev      <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
      left_hold    <= '0;
      have_left    <= 1'b0;
      sound_left   <= '0;
      sound_right  <= '0;
      sample_valid <= 1'b0;
      link_active  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bclk_rise)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;

      if (timeout) begin
        state       <= ST_SYNC;
        link_active <= 1'b0;
        have_left   <= 1'b0;
        shreg       <= '0;
        bit_cnt     <= '0;
      end else if (bclk_rise) begin
        lr_prev <= lr_s;
        if (!word_end) begin
          shreg   <= shreg_nxt;
          bit_cnt <= cnt_nxt;
        end else begin
          shreg   <= '0;
          bit_cnt <= '0;
          case (state)
            ST_SYNC: begin
              state     <= ST_RUN;
              have_left <= 1'b0;
            end
            ST_RUN: begin
              // The word just finished belongs to the channel lr was on before the edge.
              if (!lr_prev) begin
                left_hold <= word;
                have_left <= 1'b1;
              end else if (have_left) begin
                sound_left   <= left_hold;
                sound_right  <= word;
                sample_valid <= 1'b1;
                link_active  <= 1'b1;
                have_left    <= 1'b0;
              end
            end
            default: state <= ST_SYNC;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Self-checking bench for i2s_audio_rx: table-driven frames, hand-written
// reset/resync/timeout sequences and random frames against a word-level model.
`timescale 1ns/1ps
module tb_i2s_audio_rx;

  localparam int W    = 16;
  localparam int TO   = 1024;
  localparam int HALF = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        din = 1'b0;
  logic [15:0] sound_left, sound_right;
  logic        sample_valid, link_active;

  int          tests = 0;
  int          fails = 0;
  logic        d_prev = 1'b0;
  time         last_rise = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    int          lw;
    int          rw;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  i2s_audio_rx #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_din(din),
    .sound_left(sound_left), .sound_right(sound_right),
    .sample_valid(sample_valid), .link_active(link_active)
  );

  // Every pulse is logged and must follow the bclk rise that completed the right word closely.
  always @(negedge clk) begin
    if (reset_n && sample_valid) begin
      got_q.push_back({sound_left, sound_right});
      tests++;
      if ($time - last_rise > 40) begin
        fails++;
        $display("[TB] FAIL latency: got %0t after bclk rise, required <= 40ns", $time - last_rise);
      end
    end
  end

  function automatic logic [15:0] model(input logic [31:0] v, input int w);
    logic [31:0] m;
    m = (w >= 32) ? v : (v & ((32'd1 << w) - 32'd1));
    if (w >= 16) return 16'(m >> (w - 16));
    else         return 16'(m << (16 - w));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    lrclk = lr;
    din   = d;
    repeat (HALF) @(negedge clk);
    bclk = 1'b1;
    last_rise = $time;
    repeat (HALF) @(negedge clk);
    bclk = 1'b0;
  endtask

  // Data lags lrclk by one bit: MSB arrives one bclk after the lrclk edge.
  task automatic push_bit(input logic lr, input logic d);
    send_bit(lr, d_prev);
    d_prev = d;
  endtask

  task automatic send_word(input logic lr, input logic [31:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) push_bit(lr, v[i]);
  endtask

  task automatic applyStimulus(input vec_t v);
    send_word(1'b0, v.l, v.lw);
    send_word(1'b1, v.r, v.rw);
  endtask

  task automatic finish_stream();
    push_bit(1'b0, 1'b0);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b1, 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_left", {16'h0, sound_left}, 32'h0);
    checkOutput("reset_right", {16'h0, sound_right}, 32'h0);
    checkOutput("reset_valid", {31'h0, sample_valid}, 32'h0);
    checkOutput("reset_link", {31'h0, link_active}, 32'h0);
    reset_n = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_stream(input string name);
    checkOutput({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_pair%0d", name, i),
                  (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx, exp_q[i]);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{16, 16, 32'h8000,      32'hFF00,      16'h8000, 16'hFF00};
    tbl[1] = '{32, 32, 32'h5555_1234, 32'hCC33_0000, 16'h5555, 16'hCC33};
    tbl[2] = '{12, 12, 32'hABC,       32'h123,       16'hABC0, 16'h1230};
    tbl[3] = '{16, 16, 32'h8000,      32'hFF00,      16'h8000, 16'hFF00};
    tbl[4] = '{24, 20, 32'h12_3456,   32'hF_EDCB,    16'h1234, 16'hFEDC};
    tbl[5] = '{8,  2,  32'hA5,        32'h2,         16'hA500, 16'h8000};
    tbl[6] = '{17, 15, 32'h1_2345,    32'h7FFF,      16'h91A2, 16'hFFFE};

    repeat (3) @(negedge clk);

    // Reset mid-traffic: partial word discarded, next pulse only after a full L+R.
    do_reset();
    d_prev = 1'b0;
    preamble(5);
    applyStimulus('{16, 16, 32'h1111, 32'h2222, 16'h0, 16'h0});
    send_word(1'b0, 32'h3333, 16);
    send_word(1'b1, 32'h3FF, 6);
    exp_q.push_back(32'h1111_2222);
    compare_stream("pre_reset");
    do_reset();
    send_word(1'b1, 32'h3FF, 10);
    applyStimulus('{16, 16, 32'h5555, 32'h6666, 16'h0, 16'h0});
    finish_stream();
    exp_q.push_back(32'h5555_6666);
    compare_stream("post_reset");

    // Table-driven frames with mixed slot widths in one continuous stream.
    do_reset();
    d_prev = 1'b0;
    preamble(5);
    send_word(1'b0, tbl[0].l, tbl[0].lw);
    checkOutput("link_before_pulse", {31'h0, link_active}, 32'h0);
    send_word(1'b1, tbl[0].r, tbl[0].rw);
    exp_q.push_back({tbl[0].el, tbl[0].er});
    for (int i = 1; i < 7; i++) begin
      applyStimulus(tbl[i]);
      exp_q.push_back({tbl[i].el, tbl[i].er});
    end
    finish_stream();
    compare_stream("table");
    checkOutput("table_link", {31'h0, link_active}, 32'h1);

    // Stream starting mid right word and mid left word.
    do_reset();
    d_prev = 1'b0;
    preamble(5);
    for (int i = 0; i < 3; i++) begin
      v = '{16, 16, 32'(16'h1000 + i), 32'(16'h2000 + i), 16'h0, 16'h0};
      applyStimulus(v);
      exp_q.push_back({16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    end
    finish_stream();
    compare_stream("mid_right");
    do_reset();
    d_prev = 1'b0;
    send_word(1'b0, 32'h7F, 7);
    send_word(1'b1, 32'hBEEF, 16);
    applyStimulus('{16, 16, 32'hA1A1, 32'hB2B2, 16'h0, 16'h0});
    applyStimulus('{16, 16, 32'hC3C3, 32'hD4D4, 16'h0, 16'h0});
    finish_stream();
    exp_q.push_back(32'hA1A1_B2B2);
    exp_q.push_back(32'hC3C3_D4D4);
    compare_stream("mid_left");

    // Random slot widths and data against the word-level model.
    do_reset();
    d_prev = 1'b0;
    preamble(3);
    for (int i = 0; i < 10; i++) begin
      v.lw = int'($urandom_range(8, 32));
      v.rw = int'($urandom_range(8, 32));
      v.l  = $urandom;
      v.r  = $urandom;
      applyStimulus(v);
      exp_q.push_back({model(v.l, v.lw), model(v.r, v.rw)});
    end
    finish_stream();
    compare_stream("random");

    // bclk stops: link drops after the timeout, outputs hold, then resync.
    do_reset();
    d_prev = 1'b0;
    preamble(4);
    applyStimulus('{16, 16, 32'h0101, 32'h0202, 16'h0, 16'h0});
    finish_stream();
    repeat (TO - 20 - HALF) @(negedge clk);
    checkOutput("link_before_timeout", {31'h0, link_active}, 32'h1);
    repeat (30) @(negedge clk);
    checkOutput("link_after_timeout", {31'h0, link_active}, 32'h0);
    checkOutput("hold_after_timeout", {sound_left, sound_right}, 32'h0101_0202);
    exp_q.push_back(32'h0101_0202);
    d_prev = 1'b0;
    preamble(4);
    applyStimulus('{16, 16, 32'h7FFF, 32'h8001, 16'h0, 16'h0});
    finish_stream();
    exp_q.push_back(32'h7FFF_8001);
    compare_stream("resync");
    checkOutput("link_resync", {31'h0, link_active}, 32'h1);
    for (int i = 0; i < 40; i++) push_bit(1'b0, 1'($urandom));
    checkOutput("const_lr_count", 32'(got_q.size()), 32'd2);
    checkOutput("const_lr_link", {31'h0, link_active}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
